sp_update_unit: RTL and testbench
=================================

Name: sp_update_unit

Overview:
- Owns the architectural stack pointer and consumes the forwarded SP value (fwd_sp/fwd_valid) produced by the SP forwarding stage.
- Generates stack memory addresses for PUSH/POP (1 word) and CALL/RET (2 words, 32-bit PC on a 16-bit data memory).
- 2-word ops are sequenced by a small FSM that stalls upstream.
- Sits in the memory stage, directly downstream of SP forwarding.

Parameters:
SP_WIDTH, 32, width of SP and address outputs
SP_RESET, 32'h000F_FFFF, SP value after reset (empty stack; stack grows downward)
STACK_LIMIT, 32'h0000_0000, lowest legal stack address

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  stage enable; 0 freezes all state and outputs
stack_op  input  1  stack operation request this cycle
op_type  input  2  00 PUSH, 01 POP, 10 CALL, 11 RET
fwd_valid  input  1  fwd_sp holds a newer SP than sp_out
fwd_sp  input  SP_WIDTH  forwarded SP; may be high-Z when fwd_valid=0 and must then be ignored
mem_addr  output  SP_WIDTH  stack memory address, registered
mem_valid  output  1  mem_addr valid this cycle
mem_half  output  1  for 2-word ops: 0 = high half of PC, 1 = low half; 0 for 1-word ops
sp_out  output  SP_WIDTH  committed stack pointer
busy  output  1  FSM in SECOND; upstream must hold its instruction
done  output  1  one-cycle pulse when an op completes (including faulted ops)
exc_overflow  output  1  one-cycle pulse: push past STACK_LIMIT
exc_underflow  output  1  one-cycle pulse: pop past SP_RESET

Behaviour:
- Reset values (at the clk edge with rst=1): sp_out=SP_RESET, state=IDLE, mem_addr=0. mem_valid, mem_half, busy, done and both exc outputs are 0. rst has priority over en.
- rst during SECOND aborts the op: no second access and no done pulse.
- en=0: every register holds its value. Pulse outputs (mem_valid, done, exc_*) are held too, so the upstream stall logic must gate on en.
- Acceptance: the request is accepted at edge N when state=IDLE, en=1 and stack_op=1.
- Base value at acceptance: base = fwd_valid ? fwd_sp : sp_out. The base is latched for the whole op. fwd_* is ignored in SECOND.
- FSM states and transitions:
  - IDLE to SECOND on accepting CALL/RET without fault.
  - SECOND to IDLE unconditionally at the next enabled edge.
  - Faults and 1-word ops stay in IDLE.
- Operations (all arithmetic is modulo 2^SP_WIDTH, unsigned):
  - PUSH (post-decrement), after N: mem_addr=base, mem_valid=1, sp_out=base-1, done=1.
  - POP (pre-increment), after N: mem_addr=base+1, mem_valid=1, sp_out=base+1, done=1.
  - CALL, after N: mem_addr=base, mem_half=0, busy=1. After N+1: mem_addr=base-1, mem_half=1, sp_out=base-2, done=1, busy=0.
  - RET, after N: mem_addr=base+1, mem_half=1, busy=1. After N+1: mem_addr=base+2, mem_half=0, sp_out=base+2, done=1, busy=0.
- mem_valid is high for exactly one cycle per access. sp_out updates only on the final access, never mid-op.
- Fault checks, evaluated on base at acceptance:
  - PUSH faults if base < STACK_LIMIT. CALL faults if base < STACK_LIMIT+1. These raise exc_overflow.
  - POP faults if base >= SP_RESET. RET faults if base+1 >= SP_RESET. These raise exc_underflow.
  - A faulted op: exc pulse and done=1 after N, mem_valid=0, sp_out unchanged, no wrap-around ever committed.
- Requests while busy=1 are ignored. Upstream holds stack_op/op_type stable until busy=0; a held request is not re-accepted during SECOND.
- Back-to-back 1-word ops are allowed every cycle. Each uses fwd_sp when fwd_valid, otherwise the already-updated sp_out.
- stack_op=0 in IDLE: mem_valid=0, done=0, and sp_out/mem_addr hold.

Decomposition:
- Shared package: op_type encodings (OP_PUSH, OP_POP, OP_CALL, OP_RET), FSM state encodings (ST_IDLE, ST_SECOND) and the SP_RESET default. These are reused by SP forwarding and hazard logic.
- One natural sub-module: sp_bound_check. It is combinational: base and op_type in, overflow/underflow out.

Test Plan:
- Reset then PUSH with fwd_valid=0 -> next cycle mem_addr=0x000FFFFF, mem_valid=1, sp_out=0x000FFFFE, done=1.
- PUSH with fwd_valid=1, fwd_sp=0x00000100 (sp_out stale at 0x000FFFFF) -> mem_addr=0x100, sp_out=0xFF. Then POP with fwd_valid=0 -> mem_addr=0x100, sp_out=0x100.
- CALL from sp_out=0x000FFFFF, stack_op held 2 cycles -> cycle 1: addr 0x000FFFFF, half=0, busy=1, sp_out unchanged. Cycle 2: addr 0x000FFFFE, half=1, sp_out=0x000FFFFD, done=1. No third access.
- RET from sp_out=0x000FFFFD -> addrs 0x000FFFFE (half=1) then 0x000FFFFF (half=0), sp_out=0x000FFFFF.
- POP at sp_out=SP_RESET -> exc_underflow=1, done=1, mem_valid=0, sp_out stays 0x000FFFFF. With STACK_LIMIT=0x10 and sp_out=0x10, CALL -> exc_overflow=1, no busy.
- CALL accepted, rst asserted in SECOND -> next cycle sp_out=0x000FFFFF, busy=0, mem_valid=0, no done. Separately, en=0 in SECOND for 3 cycles -> busy and outputs frozen, and the second access occurs on the first edge with en=1.

Source files
------------

// File: rtl/sp_update_unit_pkg.sv
// Shared definitions for the stack-pointer datapath (SP forwarding,
// hazard logic and the SP update unit).
//   op_t    : stack operation encodings carried on op_type
//   state_t : two-word sequencing FSM states
//   SP_RESET_DEFAULT / STACK_LIMIT_DEFAULT : default stack bounds
package sp_update_unit_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  localparam logic [31:0] SP_RESET_DEFAULT    = 32'h000F_FFFF;
  localparam logic [31:0] STACK_LIMIT_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sp_update_unit_bound_check.sv
// sp_bound_check: combinational stack bound check on the base SP of a
// stack operation.
//   base      : SP value the operation starts from
//   op_type   : PUSH/POP/CALL/RET
//   overflow  : a push-type op would go below STACK_LIMIT
//   underflow : a pop-type op would go at/above SP_RESET
module sp_bound_check
  import sp_update_unit_pkg::*;
#(
  parameter int                  SP_WIDTH    = 32,
  parameter logic [SP_WIDTH-1:0] SP_RESET    = SP_WIDTH'(SP_RESET_DEFAULT),
  parameter logic [SP_WIDTH-1:0] STACK_LIMIT = SP_WIDTH'(STACK_LIMIT_DEFAULT)
) (
  input  logic [SP_WIDTH-1:0] base,
  input  logic [1:0]          op_type,
  output logic                overflow,
  output logic                underflow
);

  // Two guard bits: base+1 never wraps, and the MSB of a difference is a
  // clean borrow, so every comparison is exact with no modulo effects.
  localparam int XW = SP_WIDTH + 2;

  function automatic logic below(input logic [XW-1:0] a, input logic [XW-1:0] b);
    logic [XW-1:0] d;
    d = a - b;
    return d[XW-1];
  endfunction

  logic [XW-1:0] base_x, limit_x, reset_x, one_x;

  assign base_x  = XW'(base);
  assign limit_x = XW'(STACK_LIMIT);
  assign reset_x = XW'(SP_RESET);
  assign one_x   = XW'(1);

  always_comb begin
    overflow  = 1'b0;
    underflow = 1'b0;
    case (op_t'(op_type))
      OP_PUSH: overflow  = below(base_x, limit_x);
      OP_CALL: overflow  = below(base_x, limit_x + one_x);
      OP_POP:  underflow = !below(base_x, reset_x);
      OP_RET:  underflow = !below(base_x + one_x, reset_x);
      default: ;
    endcase
  end

endmodule

// File: rtl/sp_update_unit.sv
// sp_update_unit: owns the architectural stack pointer and generates stack
// memory addresses. 1-word ops (PUSH/POP) complete in one cycle; 2-word ops
// (CALL/RET, 32-bit PC on 16-bit memory) take two cycles and stall upstream.
//   clk, rst      : clock, synchronous active-high reset
//   en            : stage enable, 0 freezes every register
//   stack_op      : request this cycle; op_type selects PUSH/POP/CALL/RET
//   fwd_valid/sp  : forwarded SP, newer than sp_out when fwd_valid=1
//   mem_addr      : registered stack address; mem_valid qualifies it
//   mem_half      : 2-word ops, 0 = high PC half, 1 = low half
//   sp_out        : committed SP
//   busy          : second access pending, upstream must hold
//   done          : op completed (including faulted ops)
//   exc_overflow  : push below STACK_LIMIT rejected
//   exc_underflow : pop at/above SP_RESET rejected
module sp_update_unit
  import sp_update_unit_pkg::*;
#(
  parameter int                  SP_WIDTH    = 32,
  parameter logic [SP_WIDTH-1:0] SP_RESET    = SP_WIDTH'(SP_RESET_DEFAULT),
  parameter logic [SP_WIDTH-1:0] STACK_LIMIT = SP_WIDTH'(STACK_LIMIT_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                stack_op,
  input  logic [1:0]          op_type,
  input  logic                fwd_valid,
  input  logic [SP_WIDTH-1:0] fwd_sp,
  output logic [SP_WIDTH-1:0] mem_addr,
  output logic                mem_valid,
  output logic                mem_half,
  output logic [SP_WIDTH-1:0] sp_out,
  output logic                busy,
  output logic                done,
  output logic                exc_overflow,
  output logic                exc_underflow
);

  state_t              state;
  op_t                 op_p1;
  logic [SP_WIDTH-1:0] base_p1;
  logic [SP_WIDTH-1:0] base;
  logic                ovf, unf;

  // fwd_sp is only looked at when fwd_valid, so a floating bus never
  // reaches the datapath.
  assign base = fwd_valid ? fwd_sp : sp_out;

  sp_bound_check #(
    .SP_WIDTH   (SP_WIDTH),
    .SP_RESET   (SP_RESET),
    .STACK_LIMIT(STACK_LIMIT)
  ) u_bound (
    .base     (base),
    .op_type  (op_type),
    .overflow (ovf),
    .underflow(unf)
  );

  // Acceptance stage (IDLE) and second-access stage (SECOND)
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sp_out        <= SP_RESET;
      mem_addr      <= '0;
      mem_valid     <= 1'b0;
      mem_half      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      exc_overflow  <= 1'b0;
      exc_underflow <= 1'b0;
    end else if (en) begin
      mem_valid     <= 1'b0;
      done          <= 1'b0;
      exc_overflow  <= 1'b0;
      exc_underflow <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (stack_op) begin
            if (ovf || unf) begin
              // Rejected op: report and complete, commit nothing.
              exc_overflow  <= ovf;
              exc_underflow <= unf;
              done          <= 1'b1;
              mem_half      <= 1'b0;
            end else begin
              case (op_t'(op_type))
                OP_PUSH: begin
                  mem_addr  <= base;
                  mem_valid <= 1'b1;
                  mem_half  <= 1'b0;
                  sp_out    <= base - SP_WIDTH'(1);
                  done      <= 1'b1;
                end
                OP_POP: begin
                  mem_addr  <= base + SP_WIDTH'(1);
                  mem_valid <= 1'b1;
                  mem_half  <= 1'b0;
                  sp_out    <= base + SP_WIDTH'(1);
                  done      <= 1'b1;
                end
                OP_CALL: begin
                  mem_addr  <= base;
                  mem_valid <= 1'b1;
                  mem_half  <= 1'b0;
                  busy      <= 1'b1;
                  base_p1   <= base;
                  op_p1     <= OP_CALL;
                  state     <= ST_SECOND;
                end
                default: begin
                  mem_addr  <= base + SP_WIDTH'(1);
                  mem_valid <= 1'b1;
                  mem_half  <= 1'b1;
                  busy      <= 1'b1;
                  base_p1   <= base;
                  op_p1     <= OP_RET;
                  state     <= ST_SECOND;
                end
              endcase
            end
          end
        end
        ST_SECOND: begin
          // Base was latched at acceptance; SP commits only here.
          mem_valid <= 1'b1;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
          if (op_p1 == OP_CALL) begin
            mem_addr <= base_p1 - SP_WIDTH'(1);
            mem_half <= 1'b1;
            sp_out   <= base_p1 - SP_WIDTH'(2);
          end else begin
            mem_addr <= base_p1 + SP_WIDTH'(2);
            mem_half <= 1'b0;
            sp_out   <= base_p1 + SP_WIDTH'(2);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_update_unit.sv
module tb_sp_update_unit;
  import sp_update_unit_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] sp;
    logic        valid;
    logic        half;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        unf;
  } exp_t;

  typedef struct {
    logic        so;
    logic [1:0]  op;
    logic        fv;
    logic [31:0] fsp;
    exp_t        e;
  } vec_t;

  typedef struct {
    string tag;
    exp_t  e;
    bit    second;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, stack_op, fwd_valid;
  logic [1:0]  op_type;
  logic [31:0] fwd_sp;

  logic [31:0] a_mem_addr, a_sp_out, b_mem_addr, b_sp_out;
  logic a_mem_valid, a_mem_half, a_busy, a_done, a_ovf, a_unf;
  logic b_mem_valid, b_mem_half, b_busy, b_done, b_ovf, b_unf;

  sp_update_unit dut_a (
    .clk(clk), .rst(rst), .en(en), .stack_op(stack_op), .op_type(op_type),
    .fwd_valid(fwd_valid), .fwd_sp(fwd_sp),
    .mem_addr(a_mem_addr), .mem_valid(a_mem_valid), .mem_half(a_mem_half),
    .sp_out(a_sp_out), .busy(a_busy), .done(a_done),
    .exc_overflow(a_ovf), .exc_underflow(a_unf)
  );

  sp_update_unit #(.STACK_LIMIT(32'h0000_0010)) dut_b (
    .clk(clk), .rst(rst), .en(en), .stack_op(stack_op), .op_type(op_type),
    .fwd_valid(fwd_valid), .fwd_sp(fwd_sp),
    .mem_addr(b_mem_addr), .mem_valid(b_mem_valid), .mem_half(b_mem_half),
    .sp_out(b_sp_out), .busy(b_busy), .done(b_done),
    .exc_overflow(b_ovf), .exc_underflow(b_unf)
  );

  int   tests = 0;
  int   fails = 0;
  sb_t  sb_q[$];
  vec_t tbl[9];

  function automatic exp_t mk(input logic [31:0] addr, input logic [31:0] sp,
                              input logic v, input logic h, input logic b,
                              input logic d, input logic o, input logic u);
    exp_t e;
    e.addr = addr; e.sp = sp; e.valid = v; e.half = h;
    e.busy = b; e.done = d; e.ovf = o; e.unf = u;
    return e;
  endfunction

  function automatic vec_t mkv(input logic so, input logic [1:0] op, input logic fv,
                               input logic [31:0] fsp, input exp_t e);
    vec_t v;
    v.so = so; v.op = op; v.fv = fv; v.fsp = fsp; v.e = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cmp(input sb_t s);
    logic [31:0] addr, sp;
    logic v, h, b, d, o, u;
    if (s.second) begin
      addr = b_mem_addr; sp = b_sp_out; v = b_mem_valid; h = b_mem_half;
      b = b_busy; d = b_done; o = b_ovf; u = b_unf;
    end else begin
      addr = a_mem_addr; sp = a_sp_out; v = a_mem_valid; h = a_mem_half;
      b = a_busy; d = a_done; o = a_ovf; u = a_unf;
    end
    check({s.tag, ".mem_addr"},  addr,   s.e.addr);
    check({s.tag, ".sp_out"},    sp,     s.e.sp);
    check({s.tag, ".mem_valid"}, 32'(v), 32'(s.e.valid));
    check({s.tag, ".mem_half"},  32'(h), 32'(s.e.half));
    check({s.tag, ".busy"},      32'(b), 32'(s.e.busy));
    check({s.tag, ".done"},      32'(d), 32'(s.e.done));
    check({s.tag, ".exc_ovf"},   32'(o), 32'(s.e.ovf));
    check({s.tag, ".exc_unf"},   32'(u), 32'(s.e.unf));
  endtask

  // Inputs change #1 after a rising edge, well away from the next one.
  task automatic drive(input logic r, input logic e, input logic so, input logic [1:0] op,
                       input logic fv, input logic [31:0] fsp);
    rst = r; en = e; stack_op = so; op_type = op; fwd_valid = fv;
    fwd_sp = fv ? fsp : 32'hDEAD_BEEF;
  endtask

  task automatic want(input string tag, input exp_t e, input bit second);
    sb_t s;
    s.tag = tag; s.e = e; s.second = second;
    sb_q.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) cmp(sb_q.pop_front());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] m_sp, m_addr, base;
    logic        so, fv;
    logic [1:0]  op;
    logic [31:0] fsp;

    drive(1, 1, 0, OP_PUSH, 0, 0);
    want("reset_a", mk(32'h0, 32'hF_FFFF, 0, 0, 0, 0, 0, 0), 0);
    want("reset_b", mk(32'h0, 32'hF_FFFF, 0, 0, 0, 0, 0, 0), 1);
    tick();

    tbl[0] = mkv(1, OP_PUSH, 0, 0,          mk(32'hF_FFFF, 32'hF_FFFE, 1, 0, 0, 1, 0, 0));
    tbl[1] = mkv(0, OP_PUSH, 0, 0,          mk(32'hF_FFFF, 32'hF_FFFE, 0, 0, 0, 0, 0, 0));
    tbl[2] = mkv(1, OP_PUSH, 1, 32'h100,    mk(32'h100,    32'hFF,     1, 0, 0, 1, 0, 0));
    tbl[3] = mkv(1, OP_POP,  0, 0,          mk(32'h100,    32'h100,    1, 0, 0, 1, 0, 0));
    tbl[4] = mkv(1, OP_POP,  1, 32'hF_FFFF, mk(32'h100,    32'h100,    0, 0, 0, 1, 0, 1));
    tbl[5] = mkv(1, OP_POP,  1, 32'hF_FFFE, mk(32'hF_FFFF, 32'hF_FFFF, 1, 0, 0, 1, 0, 0));
    tbl[6] = mkv(1, OP_POP,  0, 0,          mk(32'hF_FFFF, 32'hF_FFFF, 0, 0, 0, 1, 0, 1));
    tbl[7] = mkv(1, OP_RET,  1, 32'hF_FFFE, mk(32'hF_FFFF, 32'hF_FFFF, 0, 0, 0, 1, 0, 1));
    tbl[8] = mkv(0, OP_PUSH, 0, 0,          mk(32'hF_FFFF, 32'hF_FFFF, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, tbl[i].so, tbl[i].op, tbl[i].fv, tbl[i].fsp);
      want($sformatf("vec%0d", i), tbl[i].e, 0);
      tick();
    end

    // CALL held for two cycles, then dropped: exactly two accesses.
    drive(0, 1, 1, OP_CALL, 0, 0);
    want("call1", mk(32'hF_FFFF, 32'hF_FFFF, 1, 0, 1, 0, 0, 0), 0); tick();
    want("call2", mk(32'hF_FFFE, 32'hF_FFFD, 1, 1, 0, 1, 0, 0), 0); tick();
    drive(0, 1, 0, OP_CALL, 0, 0);
    want("call3", mk(32'hF_FFFE, 32'hF_FFFD, 0, 1, 0, 0, 0, 0), 0); tick();

    drive(0, 1, 1, OP_RET, 0, 0);
    want("ret1", mk(32'hF_FFFE, 32'hF_FFFD, 1, 1, 1, 0, 0, 0), 0); tick();
    want("ret2", mk(32'hF_FFFF, 32'hF_FFFF, 1, 0, 0, 1, 0, 0), 0); tick();
    drive(0, 1, 0, OP_RET, 0, 0);
    want("ret3", mk(32'hF_FFFF, 32'hF_FFFF, 0, 0, 0, 0, 0, 0), 0); tick();

    // Reset in SECOND aborts the CALL: no commit, no late access.
    drive(0, 1, 1, OP_CALL, 1, 32'h2000);
    want("abort1", mk(32'h2000, 32'hF_FFFF, 1, 0, 1, 0, 0, 0), 0); tick();
    drive(1, 1, 0, OP_CALL, 0, 0);
    want("abort2", mk(32'h0, 32'hF_FFFF, 0, 0, 0, 0, 0, 0), 0); tick();
    drive(0, 1, 0, OP_CALL, 0, 0);
    want("abort3", mk(32'h0, 32'hF_FFFF, 0, 0, 0, 0, 0, 0), 0); tick();

    // en=0 in SECOND freezes everything; forwarded SP is ignored.
    drive(0, 1, 1, OP_CALL, 0, 0);
    want("frz1", mk(32'hF_FFFF, 32'hF_FFFF, 1, 0, 1, 0, 0, 0), 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, OP_CALL, 1, 32'h55);
      want($sformatf("frz_hold%0d", i), mk(32'hF_FFFF, 32'hF_FFFF, 1, 0, 1, 0, 0, 0), 0);
      tick();
    end
    drive(0, 1, 1, OP_CALL, 0, 0);
    want("frz2", mk(32'hF_FFFE, 32'hF_FFFD, 1, 1, 0, 1, 0, 0), 0); tick();
    drive(0, 0, 1, OP_PUSH, 0, 0);
    want("frz_idle", mk(32'hF_FFFE, 32'hF_FFFD, 1, 1, 0, 1, 0, 0), 0); tick();
    drive(0, 1, 0, OP_PUSH, 0, 0);
    want("frz3", mk(32'hF_FFFE, 32'hF_FFFD, 0, 1, 0, 0, 0, 0), 0); tick();

    // Overflow boundaries on the STACK_LIMIT=0x10 instance.
    drive(1, 1, 0, OP_PUSH, 0, 0); tick();
    drive(0, 1, 1, OP_PUSH, 1, 32'h11);
    want("lim_push", mk(32'h11, 32'h10, 1, 0, 0, 1, 0, 0), 1); tick();
    drive(0, 1, 1, OP_CALL, 0, 0);
    want("lim_call", mk(32'h11, 32'h10, 0, 0, 0, 1, 1, 0), 1); tick();
    drive(0, 1, 1, OP_PUSH, 0, 0);
    want("lim_push_at", mk(32'h10, 32'hF, 1, 0, 0, 1, 0, 0), 1); tick();
    want("lim_push_below", mk(32'h10, 32'hF, 0, 0, 0, 1, 1, 0), 1); tick();

    // Random back-to-back 1-word ops against a reference model.
    drive(1, 1, 0, OP_PUSH, 0, 0); tick();
    m_sp = 32'hF_FFFF;
    m_addr = 32'h0;
    for (int i = 0; i < 40; i++) begin
      so  = ($urandom_range(0, 3) != 0);
      op  = $urandom_range(0, 1) != 0 ? OP_POP : OP_PUSH;
      fv  = ($urandom_range(0, 1) != 0);
      fsp = 32'h000F_FF00 + 32'($urandom_range(0, 255));
      drive(0, 1, so, op, fv, fsp);
      base = fv ? fsp : m_sp;
      if (!so) begin
        want($sformatf("rnd%0d", i), mk(m_addr, m_sp, 0, 0, 0, 0, 0, 0), 0);
      end else if (op == OP_PUSH) begin
        m_addr = base;
        m_sp = base - 32'd1;
        want($sformatf("rnd%0d", i), mk(m_addr, m_sp, 1, 0, 0, 1, 0, 0), 0);
      end else if (base >= 32'hF_FFFF) begin
        want($sformatf("rnd%0d", i), mk(m_addr, m_sp, 0, 0, 0, 1, 0, 1), 0);
      end else begin
        m_addr = base + 32'd1;
        m_sp = base + 32'd1;
        want($sformatf("rnd%0d", i), mk(m_addr, m_sp, 1, 0, 0, 1, 0, 0), 0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
